// File: rtl/bist_response_analyzer.sv
// Memory BIST read checker: aligns issued reads with returning data, logs errors.
// Ports: clk, reset(n), start/rd_en/rd_addr/exp_data/last/rd_data in; status out.
module bist_response_analyzer #(
  parameter int a_width = 4,
  parameter int d_width = 8,
  parameter int RD_LAT  = 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               rd_en,
  input  logic [a_width-1:0] rd_addr,
  input  logic [d_width-1:0] exp_data,
  input  logic               last,
  input  logic [d_width-1:0] rd_data,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               fail_flag,
  output logic [a_width-1:0] first_fail_addr,
  output logic [d_width-1:0] first_fail_xor,
  output logic [CNT_W-1:0]   err_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;

  logic [RD_LAT-1:0]  pv;
  logic [a_width-1:0] pa [RD_LAT];
  logic [d_width-1:0] pe [RD_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pa[i] <= '0;
        pe[i] <= '0;
      end
    end else begin
      pv[0] <= rd_en & (state == RUN);
      pa[0] <= rd_addr;
      pe[0] <= exp_data;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end

  logic               out_v;
  logic [a_width-1:0] out_a;
  logic [d_width-1:0] diff;
  logic               miss;
  logic [CNT_W-1:0]   err_nxt;
  logic               pend;

  assign out_v = pv[RD_LAT-1];
  assign out_a = pa[RD_LAT-1];
  assign diff  = rd_data ^ pe[RD_LAT-1];
  assign miss  = out_v && (diff != '0);

  assign err_nxt = (miss && (err_count != '1))
                 ? err_count + 1'b1 : err_count;

  // Entries still ahead of the output stage; the output stage itself
  // is compared on the same edge that leaves DRAIN.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pend = pend | pv[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_flag       <= 1'b0;
      first_fail_addr <= '0;
      first_fail_xor  <= '0;
      err_count       <= '0;
    end else begin
      if (miss) begin
        err_count <= err_nxt;
        if (!fail_flag) begin
          fail_flag       <= 1'b1;
          first_fail_addr <= out_a;
          first_fail_xor  <= diff;
        end
      end
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_flag       <= 1'b0;
            first_fail_addr <= '0;
            first_fail_xor  <= '0;
            err_count       <= '0;
          end
        end
        RUN: begin
          if (rd_en && last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!pend) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench for bist_response_analyzer: two instances (RD_LAT 1/CNT_W 8, RD_LAT 3/CNT_W 2)
// share the read stream; a pass-level model feeds per-instance scoreboards.
module tb_bist_response_analyzer;

  localparam int L0 = 1;
  localparam int C0 = 8;
  localparam int L1 = 3;
  localparam int C1 = 2;

  logic       clk;
  logic       reset;
  logic       start;
  logic       rd_en;
  logic       last;
  logic [3:0] rd_addr;
  logic [7:0] exp_data;
  logic [7:0] corr;
  logic [7:0] mp [3];
  logic [7:0] rd_data0;
  logic [7:0] rd_data1;

  logic          busy0, done0, pass0, ff0;
  logic [3:0]    fa0;
  logic [7:0]    fx0;
  logic [C0-1:0] ec0;
  logic          busy1, done1, pass1, ff1;
  logic [3:0]    fa1;
  logic [7:0]    fx1;
  logic [C1-1:0] ec1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int err;
    int ff;
    int faddr;
    int fxor;
    int ps;
    int dcyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  bist_response_analyzer #(
    .a_width(4), .d_width(8), .RD_LAT(L0), .CNT_W(C0)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .rd_en(rd_en),
    .rd_addr(rd_addr), .exp_data(exp_data), .last(last),
    .rd_data(rd_data0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_flag(ff0), .first_fail_addr(fa0), .first_fail_xor(fx0),
    .err_count(ec0)
  );

  bist_response_analyzer #(
    .a_width(4), .d_width(8), .RD_LAT(L1), .CNT_W(C1)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .rd_en(rd_en),
    .rd_addr(rd_addr), .exp_data(exp_data), .last(last),
    .rd_data(rd_data1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_flag(ff1), .first_fail_addr(fa1), .first_fail_xor(fx1),
    .err_count(ec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory under test: returns exp_data (xor a chosen corruption) after latency.
  always @(posedge clk) begin
    mp[0] <= exp_data ^ corr;
    mp[1] <= mp[0];
    mp[2] <= mp[1];
  end
  assign rd_data0 = mp[L0-1];
  assign rd_data1 = mp[L1-1];

  task automatic check(string nm, int act, int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, expv, expv);
    end
  endtask

  task automatic cmp(string t, exp_t e, int ec, int ff, int fa,
                     int fx, int ps);
    check({t, "_err_count"}, ec, e.err);
    check({t, "_fail_flag"}, ff, e.ff);
    check({t, "_first_addr"}, fa, e.faddr);
    check({t, "_first_xor"}, fx, e.fxor);
    check({t, "_pass"}, ps, e.ps);
    check({t, "_done_cycle"}, cyc, e.dcyc);
  endtask

  logic pd0 = 1'b0;
  logic pd1 = 1'b0;

  always @(negedge clk) begin
    if (reset && done0 && !pd0) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut0_spurious_done: got done=1 required no done");
      end else begin
        exp_t e;
        e = q0.pop_front();
        cmp("dut0", e, int'(ec0), int'(ff0), int'(fa0),
            int'(fx0), int'(pass0));
      end
    end
    pd0 = done0;
  end

  always @(negedge clk) begin
    if (reset && done1 && !pd1) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dut1_spurious_done: got done=1 required no done");
      end else begin
        exp_t e;
        e = q1.pop_front();
        cmp("dut1", e, int'(ec1), int'(ff1), int'(fa1),
            int'(fx1), int'(pass1));
      end
    end
    pd1 = done1;
  end

  task automatic junk();
    start    = 1'b0;
    rd_en    = 1'($urandom_range(0, 1));
    last     = 1'($urandom_range(0, 1));
    rd_addr  = 4'($urandom);
    exp_data = 8'($urandom);
    corr     = 8'($urandom);
  endtask

  task automatic check_zero(string t, bit bz);
    check({t, "_busy0"}, int'(busy0), int'(bz));
    check({t, "_busy1"}, int'(busy1), int'(bz));
    check({t, "_done0"}, int'(done0), 0);
    check({t, "_done1"}, int'(done1), 0);
    check({t, "_pass0"}, int'(pass0), 0);
    check({t, "_pass1"}, int'(pass1), 0);
    check({t, "_ff0"}, int'(ff0), 0);
    check({t, "_ff1"}, int'(ff1), 0);
    check({t, "_fa0"}, int'(fa0), 0);
    check({t, "_fa1"}, int'(fa1), 0);
    check({t, "_fx0"}, int'(fx0), 0);
    check({t, "_fx1"}, int'(fx1), 0);
    check({t, "_ec0"}, int'(ec0), 0);
    check({t, "_ec1"}, int'(ec1), 0);
  endtask

  // One test pass. f1/f2 are read indices forced to mismatch (f1 uses x1),
  // rate is the percent chance of a random mismatch on other reads.
  task automatic run_pass(int n, bit down, int a0, int rate, int f1,
                          int f2, int x1, bit fixed, bit mid, bit abort);
    int   errs;
    int   faddr;
    int   fxor;
    int   lastcyc;
    int   a;
    int   k;
    exp_t e;
    errs  = 0;
    faddr = 0;
    fxor  = 0;
    lastcyc = 0;
    @(posedge clk); #1;
    junk();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rd_en = 1'b0;
    last  = 1'b0;
    @(negedge clk);
    check_zero("after_start", 1'b1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      while ($urandom_range(0, 3) == 0) begin
        start = 1'b0;
        rd_en = 1'b0;
        last  = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      a = down ? (a0 - i) & 15 : (a0 + i) & 15;
      start    = mid && (i == n / 2);
      rd_en    = 1'b1;
      last     = (i == n - 1);
      rd_addr  = 4'(a);
      exp_data = fixed ? 8'hA5 : 8'($urandom);
      if (i == f1) corr = 8'(x1);
      else if (i == f2) corr = 8'($urandom_range(1, 255));
      else if (int'($urandom_range(1, 100)) <= rate)
        corr = 8'($urandom_range(1, 255));
      else corr = 8'h00;
      if (corr != 0) begin
        if (errs == 0) begin
          faddr = a;
          fxor  = int'(corr);
        end
        errs++;
      end
      lastcyc = cyc;
    end
    @(posedge clk); #1;
    junk();
    if (abort) begin
      check("abort_ff0_before_reset", int'(ff0), int'(errs > 0));
      reset = 1'b0;
      #1;
      check_zero("reset_in_drain", 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_zero("after_reset_release", 1'b0);
      return;
    end
    e.ff    = int'(errs > 0);
    e.faddr = faddr;
    e.fxor  = fxor;
    e.ps    = int'(errs == 0);
    e.err   = (errs > (1 << C0) - 1) ? (1 << C0) - 1 : errs;
    e.dcyc  = lastcyc + L0 + 1;
    q0.push_back(e);
    e.err   = (errs > (1 << C1) - 1) ? (1 << C1) - 1 : errs;
    e.dcyc  = lastcyc + L1 + 1;
    q1.push_back(e);
    k = 0;
    while (!(done0 && done1) && k < 30) begin
      @(posedge clk); #1;
      junk();
      k++;
    end
    if (!(done0 && done1)) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got done0=%0d done1=%0d required 1 1",
               done0, done1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rd_en    = 1'b0;
    last     = 1'b0;
    rd_addr  = '0;
    exp_data = '0;
    corr     = '0;
    repeat (3) @(negedge clk);
    check_zero("reset", 1'b0);
    reset = 1'b1;

    run_pass(16, 1'b0, 0, 0, -1, -1, 0, 1'b1, 1'b0, 1'b0);
    run_pass(16, 1'b0, 0, 0, 5, -1, 8'h04, 1'b0, 1'b0, 1'b0);
    run_pass(16, 1'b1, 15, 0, 6, 12, 8'h10, 1'b0, 1'b0, 1'b0);
    run_pass(6, 1'b0, 3, 100, -1, -1, 0, 1'b0, 1'b0, 1'b0);
    run_pass(16, 1'b0, 10, 0, 2, -1, 8'h80, 1'b0, 1'b1, 1'b0);
    run_pass(8, 1'b0, 0, 0, 0, -1, 8'h01, 1'b0, 1'b0, 1'b1);
    run_pass(16, 1'b0, 0, 0, -1, -1, 0, 1'b0, 1'b0, 1'b0);
    run_pass(1, 1'b1, 0, 0, 0, -1, 8'hFF, 1'b0, 1'b0, 1'b0);

    repeat (25) begin
      run_pass(int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), 15, -1, -1, 0, 1'b0,
               1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (4) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
